// File: rtl/resize_pkg.sv
// Shared definitions for the 2:1 box-filter downscale path: sequencer states,
// default frame geometry and the width helpers used to size counters and addresses.
package resize_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        RUN   = 2'd2,
        FIN   = 2'd3
    } state_t;

    // Returns at least 1 so that degenerate sizes still give a legal vector width.
    function automatic int unsigned width_of(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    localparam int unsigned FRAME_W = 768;
    localparam int unsigned FRAME_H = 512;
    localparam int unsigned COL_W   = width_of(FRAME_W);
    localparam int unsigned ROW_W   = width_of(FRAME_H);
    localparam int unsigned ADDR_W  = width_of(FRAME_W / 2);

endpackage

// File: rtl/resize_pos_counter.sv
// Column/row pixel position counter with synchronous clear, count enable,
// column wrap into the next row and a last-pixel flag.
module resize_pos_counter
    import resize_pkg::*;
#(
    parameter int unsigned W  = FRAME_W,
    parameter int unsigned H  = FRAME_H,
    parameter int unsigned CW = width_of(W),
    parameter int unsigned RW = width_of(H)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_clr,
    input  logic          i_en,
    output logic [CW-1:0] o_col,
    output logic [RW-1:0] o_row,
    output logic          o_last
);

    localparam logic [CW-1:0] COL_LAST = CW'(W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(H - 1);

    logic [CW-1:0] r_col;
    logic [RW-1:0] r_row;
    logic          w_col_end;

    assign w_col_end = (r_col == COL_LAST);
    assign o_last    = w_col_end && (r_row == ROW_LAST);
    assign o_col     = r_col;
    assign o_row     = r_row;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_col <= '0;
            r_row <= '0;
        end else if (i_clr) begin
            r_col <= '0;
            r_row <= '0;
        end else if (i_en) begin
            if (w_col_end) begin
                r_col <= '0;
                r_row <= o_last ? '0 : r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

endmodule

// File: rtl/resize_ctrl_2x2.sv
// Sequencer for the 2:1 box-filter downscale: frame FSM, accumulator and
// line-buffer strobe decode, output coordinates and sticky status flags.
module resize_ctrl_2x2
    import resize_pkg::*;
#(
    parameter int unsigned IN_W = FRAME_W,
    parameter int unsigned IN_H = FRAME_H,
    parameter int unsigned AW   = width_of(IN_W / 2),
    parameter int unsigned CW   = width_of(IN_W),
    parameter int unsigned RW   = width_of(IN_H)
) (
    input  logic          horizontal_clock,
    input  logic          horizontal_reset,
    input  logic          start,
    input  logic          horizontal_sync,
    input  logic          src_done,
    output logic          acc_load,
    output logic          acc_add,
    output logic          lb_wr_en,
    output logic [AW-1:0] lb_addr,
    output logic          out_valid,
    output logic [CW-2:0] out_col,
    output logic [RW-2:0] out_row,
    output logic          busy,
    output logic          done,
    output logic          short_frame,
    output logic          overrun
);

    state_t        r_state;
    logic          r_busy;
    logic          r_done;
    logic          r_short;
    logic          r_overrun;

    logic [CW-1:0] w_col;
    logic [RW-1:0] w_row;
    logic          w_last;
    logic          w_active;
    logic          w_accept;
    logic          w_clr;

    assign w_active = (r_state == ARMED) || (r_state == RUN);
    assign w_accept = w_active && horizontal_sync;
    assign w_clr    = (r_state == IDLE) && start;

    resize_pos_counter #(
        .W  (IN_W),
        .H  (IN_H),
        .CW (CW),
        .RW (RW)
    ) u_pos (
        .i_clk  (horizontal_clock),
        .i_rst  (horizontal_reset),
        .i_clr  (w_clr),
        .i_en   (w_accept),
        .o_col  (w_col),
        .o_row  (w_row),
        .o_last (w_last)
    );

    // Strobes decode the position of the pixel being accepted this cycle.
    assign acc_load  = w_accept && !w_col[0];
    assign acc_add   = w_accept &&  w_col[0];
    assign lb_wr_en  = w_accept &&  w_col[0] && !w_row[0];
    assign out_valid = w_accept &&  w_col[0] &&  w_row[0];
    assign lb_addr   = AW'(w_col[CW-1:1]);
    assign out_col   = w_col[CW-1:1];
    assign out_row   = w_row[RW-1:1];

    assign busy        = r_busy;
    assign done        = r_done;
    assign short_frame = r_short;
    assign overrun     = r_overrun;

    always_ff @(posedge horizontal_clock or posedge horizontal_reset) begin
        if (horizontal_reset) begin
            r_state   <= IDLE;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_short   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state   <= ARMED;
                        r_busy    <= 1'b1;
                        r_short   <= 1'b0;
                        r_overrun <= 1'b0;
                    end else if (horizontal_sync) begin
                        r_overrun <= 1'b1;
                    end
                end
                ARMED, RUN: begin
                    // Last pixel takes priority over a coincident src_done.
                    if (w_accept && w_last) begin
                        r_state <= FIN;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else if (src_done) begin
                        r_state <= FIN;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_short <= 1'b1;
                    end else if (w_accept) begin
                        r_state <= RUN;
                    end
                end
                FIN: begin
                    r_state <= IDLE;
                    if (horizontal_sync) begin
                        r_overrun <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_resize_ctrl_2x2.sv
// Directed bench for resize_ctrl_2x2 on an 8x4 frame: table-driven pixel
// vectors plus hand-written sequences for stalls, short frames, overrun and abort.
module tb_resize_ctrl_2x2;

    localparam int unsigned W = 8;
    localparam int unsigned H = 4;

    logic       clk;
    logic       rst;
    logic       start;
    logic       sync;
    logic       src_done;
    logic       acc_load;
    logic       acc_add;
    logic       lb_wr_en;
    logic [1:0] lb_addr;
    logic       out_valid;
    logic [1:0] out_col;
    logic [0:0] out_row;
    logic       busy;
    logic       done;
    logic       short_frame;
    logic       overrun;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic       sync;
        logic [8:0] exp;
    } vec_t;

    vec_t tbl[32];

    resize_ctrl_2x2 #(
        .IN_W (W),
        .IN_H (H)
    ) dut (
        .horizontal_clock (clk),
        .horizontal_reset (rst),
        .start            (start),
        .horizontal_sync  (sync),
        .src_done         (src_done),
        .acc_load         (acc_load),
        .acc_add          (acc_add),
        .lb_wr_en         (lb_wr_en),
        .lb_addr          (lb_addr),
        .out_valid        (out_valid),
        .out_col          (out_col),
        .out_row          (out_row),
        .busy             (busy),
        .done             (done),
        .short_frame      (short_frame),
        .overrun          (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [8:0] strobes();
        return {acc_load, acc_add, lb_wr_en, out_valid, lb_addr, out_col, out_row};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full frame; toggle inserts a stall after every pixel, src_last raises src_done with the last pixel.
    task automatic frame(input bit toggle, input bit src_last);
        int k;
        int n;
        k = 0;
        n = toggle ? 63 : 32;
        start = 1'b1;
        tick();
        start = 1'b0;
        #2;
        chk("armed_busy", busy, 1);
        tick();
        for (int i = 0; i < n; i++) begin
            sync     = toggle ? (i % 2 == 0) : 1'b1;
            src_done = src_last && sync && (k == 31);
            #2;
            if (sync) begin
                chk($sformatf("pix%0d", k), strobes(), tbl[k].exp);
                k++;
            end else begin
                chk("stall_strobes", strobes() >> 5, 0);
            end
            tick();
        end
        sync     = 1'b0;
        src_done = 1'b0;
        #2;
        chk("frame_done", done, 1);
        chk("frame_busy", busy, 0);
        chk("frame_short", short_frame, 0);
        tick();
        chk("done_once", done, 0);
    endtask

    initial begin
        logic [2:0] c;
        logic [1:0] r;
        int ov;
        int dones;

        for (int i = 0; i < 32; i++) begin
            c = 3'(i % 8);
            r = 2'(i / 8);
            tbl[i].sync = 1'b1;
            tbl[i].exp  = {~c[0], c[0], c[0] & ~r[0], c[0] & r[0], c[2:1], c[2:1], r[1]};
        end

        rst = 1'b1; start = 1'b0; sync = 1'b0; src_done = 1'b0;
        tick();
        tick();
        #2;
        chk("reset_outputs", {strobes(), busy, done, short_frame, overrun}, 0);
        rst = 1'b0;
        tick();

        // back-to-back frame
        frame(1'b0, 1'b0);

        // one stall cycle after every pixel
        frame(1'b1, 1'b0);

        // src_done with the last pixel: last pixel wins
        frame(1'b0, 1'b1);

        // short frame: src_done after 20 pixels
        ov = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            sync = 1'b1;
            #2;
            if (out_valid) ov++;
            tick();
        end
        sync = 1'b0;
        src_done = 1'b1;
        tick();
        src_done = 1'b0;
        #2;
        chk("short_done", done, 1);
        chk("short_flag", short_frame, 1);
        chk("short_ov_count", ov, 4);
        tick();
        chk("short_sticky", short_frame, 1);
        chk("short_done_once", done, 0);
        chk("short_idle_busy", busy, 0);

        // sync while idle
        sync = 1'b1;
        #2;
        chk("idle_no_strobes", strobes() >> 5, 0);
        tick();
        sync = 1'b0;
        #2;
        chk("overrun_set", overrun, 1);
        tick();
        chk("overrun_hold", overrun, 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        #2;
        chk("overrun_clr", overrun, 0);
        chk("short_clr", short_frame, 0);
        src_done = 1'b1;
        tick();
        src_done = 1'b0;
        tick();

        // reset mid-frame after 13 pixels
        dones = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 13; i++) begin
            sync = 1'b1;
            tick();
        end
        rst = 1'b1;
        #2;
        chk("abort_outputs", {strobes(), busy, done, short_frame, overrun}, 0);
        sync = 1'b0;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #2;
            if (done) dones++;
            tick();
        end
        chk("abort_no_done", dones, 0);
        frame(1'b0, 1'b0);

        // start during RUN is ignored
        dones = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 32; i++) begin
            sync  = 1'b1;
            start = (i == 10);
            #2;
            chk($sformatf("rs_pix%0d", i), strobes(), tbl[i].exp);
            tick();
        end
        sync = 1'b0;
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #2;
            if (done) dones++;
            tick();
        end
        chk("rs_single_done", dones, 1);
        chk("rs_idle_busy", busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
